dct2_2d_scheduler: RTL and testbench
====================================

// Module: dct2_2d_scheduler
// PURPOSE
//  Sequences one NxN 2-D DCT-II block through the shared 1-D DCT core: row pass (input rows -> core ->
//  transpose buffer), then column pass (transpose buffer -> core -> output). Owns start/done,
//  row/column counters, transpose-buffer addressing, the core pipeline tags and output backpressure.
//  Sits between the input block FIFO, the 1-D core, the transpose RAM and the output stage.
// PARAMETERS
//  CORE_LAT  2  pipeline latency of the 1-D core, cycles from core_en to result (>=1)
//  RD_LAT    1  transpose-buffer read latency, cycles from tbuf_re to data at the core input (fixed 1)
//  CW        5  counter width; covers N up to 32
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-low reset
//  start       in   1   begin one block; sampled only in IDLE
//  N           in   2   size code 00=4, 01=8, 10=16, 11=32; latched on accepted start
//  in_valid    in   1   input row available
//  in_ready    out  1   scheduler accepts input row this cycle
//  core_en     out  1   issue one vector into the 1-D core this cycle
//  core_hold   out  1   freeze core pipeline (column-pass backpressure)
//  direction   out  1   0 = row pass, 1 = column pass (core coefficient select)
//  tbuf_we     out  1   transpose-buffer write strobe
//  tbuf_waddr  out  CW  row index of the row result being written
//  tbuf_re     out  1   transpose-buffer read strobe
//  tbuf_raddr  out  CW  column index being read
//  out_valid   out  1   column result at core output is valid
//  out_ready   in   1   downstream accepts the column result
//  out_idx     out  CW  column index of the presented result
//  busy        out  1   high in every state except IDLE
//  done        out  1   one-cycle pulse after the last column is accepted
//  current_state out 3  FSM state encoding (debug)
// BEHAVIOUR
//  Reset: every output 0, FSM = IDLE, all counters and tag pipes cleared; async assert, sync release.
//  Nsz = 4 << N_latched. States: IDLE=0, ROW=1, ROW_DRAIN=2, COL=3, COL_DRAIN=4, DONE=5.
//  IDLE: start=1 -> latch N, clear counters, -> ROW next cycle. start while busy: ignored.
//  ROW: in_ready = (iss_cnt < Nsz). in_valid&in_ready -> core_en=1, tag=iss_cnt enters a CORE_LAT pipe,
//   iss_cnt++. iss_cnt==Nsz -> ROW_DRAIN. Row pass never stalls after issue.
//  Tag emerging from the pipe -> tbuf_we=1, tbuf_waddr=tag, wr_cnt++. First write exactly CORE_LAT cycles
//   after first core_en. ROW_DRAIN -> COL the cycle after the write with wr_cnt==Nsz-1 completes.
//  COL: direction=1. hold = out_valid & ~out_ready; core_hold = hold. Issue when !hold & iss_cnt<Nsz:
//   tbuf_re=1, tbuf_raddr=iss_cnt; one cycle later core_en=1; tag pipe depth RD_LAT+CORE_LAT.
//   While hold the tag pipe and the core_en stage freeze (no tag lost, none duplicated).
//   iss_cnt==Nsz -> COL_DRAIN.
//  out_valid = tag at pipe head; out_idx = that tag; handshake completes on out_valid&out_ready.
//   out_cnt++ per completed handshake; out_valid stays high with stable out_idx until accepted.
//  COL_DRAIN -> DONE on the handshake with out_cnt==Nsz-1; DONE: done=1 one cycle, -> IDLE.
//  Counters are CW bits, range 0..Nsz; compares use Nsz zero-extended; no wrap within a block.
//  N=11 (32): iss_cnt reaches 32 -> CW must hold 32; CW=6 internally for iss/wr/out counters.
//  in_valid low in ROW: no issue, no state change. out_ready low forever: FSM parks in COL/COL_DRAIN.
//  Reset mid-block: immediate IDLE, partial block discarded, no done pulse.
// STRUCTURE
//  dct2_pkg: state enum/localparams, size_decode(N) -> Nsz function, CORE_LAT/RD_LAT defaults.
//  Sub-module dct2_tag_pipe (DEPTH, W, stall input): valid+tag shift register, reused for both passes.
// TESTING
//  N=00, in_valid=1, out_ready=1: 4 core_en rows, tbuf writes at cycles +2..+5, 4 outputs, done 1 pulse.
//  N=11, in_valid=1, out_ready=1: exactly 32 writes addr 0..31, 32 reads 0..31, out_idx 0..31 in order.
//  N=01, in_valid toggling 1/0: 8 rows issued, in_ready=0 after 8th, done only after 8th output.
//  N=01, out_ready=0 for 5 cycles at out_idx=3: out_valid/out_idx held, core_hold=1, no skip/duplicate.
//  Reset driven low mid-COL (N=10): all outputs 0 immediately, state=0; new start runs a clean block.
//  start=1 while busy: no relatch of N; N change mid-block has no effect on Nsz.

Source files
------------

// File: rtl/dct2_2d_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dct2_2d_scheduler_pkg
// Description : Shared types and helpers for the 2-D DCT-II block scheduler:
//               FSM state encoding, default latencies and the size decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package dct2_2d_scheduler_pkg;

    localparam int c_core_lat_def = 2;  // 1-D core latency, core_en -> result
    localparam int c_rd_lat_def   = 1;  // transpose-buffer read latency
    localparam int c_cw_def       = 5;  // address / tag width (N up to 32)
    localparam int c_cnt_w        = 6;  // counters must be able to hold 32

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ROW       = 3'd1,
        S_ROW_DRAIN = 3'd2,
        S_COL       = 3'd3,
        S_COL_DRAIN = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    // Block size from the 2-bit size code: 00=4, 01=8, 10=16, 11=32.
    function automatic logic [c_cnt_w-1:0] size_decode(input logic [1:0] n);
        return c_cnt_w'(4) << n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dct2_2d_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : dct2_2d_scheduler_if
// Description : Datapath-facing handshake bundle of the 2-D DCT scheduler.
//               master : scheduler side (drives strobes, addresses, tags)
//               slave  : environment side (input FIFO, core, tbuf, output)
//               Signals: in_valid/in_ready, core_en/core_hold/direction,
//               tbuf_we/tbuf_waddr, tbuf_re/tbuf_raddr,
//               out_valid/out_ready/out_idx.
// Revision    : 1.0 - initial release
// ============================================================================
interface dct2_2d_scheduler_if #(
    parameter int CW = 5
) ();
    logic          in_valid;
    logic          in_ready;
    logic          core_en;
    logic          core_hold;
    logic          direction;
    logic          tbuf_we;
    logic [CW-1:0] tbuf_waddr;
    logic          tbuf_re;
    logic [CW-1:0] tbuf_raddr;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_idx;

    modport master (
        input  in_valid, out_ready,
        output in_ready, core_en, core_hold, direction,
               tbuf_we, tbuf_waddr, tbuf_re, tbuf_raddr,
               out_valid, out_idx
    );

    modport slave (
        output in_valid, out_ready,
        input  in_ready, core_en, core_hold, direction,
               tbuf_we, tbuf_waddr, tbuf_re, tbuf_raddr,
               out_valid, out_idx
    );
endinterface
`default_nettype wire

// File: rtl/dct2_2d_scheduler_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dct2_2d_scheduler_tag_pipe
// Description : Valid + tag shift register that shadows the 1-D core pipeline
//               so the scheduler knows which row/column emerges when.
//               clk, rst_n  : clock, async active-low reset
//               stall       : freeze every stage (bubbles included)
//               in_valid/in_tag   : entry into the pipe
//               out_valid/out_tag : head of the pipe (DEPTH cycles later)
// Revision    : 1.0 - initial release
// ============================================================================
module dct2_2d_scheduler_tag_pipe #(
    parameter int DEPTH = 2,
    parameter int W     = 5
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         stall,
    input  wire logic         in_valid,
    input  wire logic [W-1:0] in_tag,
    output logic              out_valid,
    output logic [W-1:0]      out_tag
);

    logic [DEPTH-1:0] r_vld;
    logic [W-1:0]     r_tag [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i] <= '0;
            end
        end else if (!stall) begin
            r_vld[0] <= in_valid;
            r_tag[0] <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign out_valid = r_vld[DEPTH-1];
    assign out_tag   = r_tag[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/dct2_2d_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dct2_2d_scheduler
// Description : Sequences one NxN 2-D DCT-II block through a shared 1-D core:
//               row pass (input rows -> core -> transpose buffer), then
//               column pass (transpose buffer -> core -> output stage).
//               clk, rst_n    : clock, async active-low reset
//               start, N      : begin a block, size code (latched in IDLE)
//               bus (master)  : input/core/tbuf/output handshakes
//               busy, done    : activity flag, one-cycle completion pulse
//               current_state : FSM encoding for debug
// Revision    : 1.0 - initial release
// ============================================================================
module dct2_2d_scheduler
    import dct2_2d_scheduler_pkg::*;
#(
    parameter int CORE_LAT = c_core_lat_def,
    parameter int RD_LAT   = c_rd_lat_def,
    parameter int CW       = c_cw_def
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    input  wire logic [1:0]        N,
    dct2_2d_scheduler_if.master    bus,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             current_state
);

    // One extra bit so the counters can reach Nsz itself (32 at CW=5).
    localparam int CNT_W     = CW + 1;
    localparam int COL_DEPTH = RD_LAT + CORE_LAT;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_nsz;
    logic [CNT_W-1:0]   r_iss_cnt;
    logic [CNT_W-1:0]   r_wr_cnt;
    logic [CNT_W-1:0]   r_out_cnt;
    logic               r_col_en;

    logic               w_iss_below;
    logic               w_hold;
    logic               w_row_issue;
    logic               w_col_issue;
    logic               w_out_fire;
    logic               w_row_vld;
    logic [CW-1:0]      w_row_tag;
    logic               w_col_vld;
    logic [CW-1:0]      w_col_tag;
    logic               w_last_wr;
    logic               w_last_out;

    assign w_iss_below = (r_iss_cnt < r_nsz);
    assign w_hold      = w_col_vld & ~bus.out_ready;
    assign w_row_issue = (r_state == S_ROW) & w_iss_below & bus.in_valid;
    assign w_col_issue = (r_state == S_COL) & w_iss_below & ~w_hold;
    assign w_out_fire  = w_col_vld & bus.out_ready;
    assign w_last_wr   = w_row_vld  & (r_wr_cnt  == r_nsz - CNT_W'(1));
    assign w_last_out  = w_out_fire & (r_out_cnt == r_nsz - CNT_W'(1));

    // Row pass: result appears CORE_LAT cycles after issue, never stalls.
    dct2_2d_scheduler_tag_pipe #(
        .DEPTH (CORE_LAT),
        .W     (CW)
    ) u_row_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (1'b0),
        .in_valid  (w_row_issue),
        .in_tag    (r_iss_cnt[CW-1:0]),
        .out_valid (w_row_vld),
        .out_tag   (w_row_tag)
    );

    // Column pass: tag enters with the tbuf read, so depth covers the read
    // latency too; it freezes together with the core on backpressure.
    dct2_2d_scheduler_tag_pipe #(
        .DEPTH (COL_DEPTH),
        .W     (CW)
    ) u_col_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (w_hold),
        .in_valid  (w_col_issue),
        .in_tag    (r_iss_cnt[CW-1:0]),
        .out_valid (w_col_vld),
        .out_tag   (w_col_tag)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (start) w_next = S_ROW;
            S_ROW:       if (r_iss_cnt == r_nsz) w_next = S_ROW_DRAIN;
            // wr_cnt==Nsz covers a short core whose last write lands in ROW.
            S_ROW_DRAIN: if (w_last_wr || (r_wr_cnt == r_nsz)) w_next = S_COL;
            S_COL:       if (r_iss_cnt == r_nsz) w_next = S_COL_DRAIN;
            S_COL_DRAIN: if (w_last_out || (r_out_cnt == r_nsz)) w_next = S_DONE;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_nsz     <= '0;
            r_iss_cnt <= '0;
            r_wr_cnt  <= '0;
            r_out_cnt <= '0;
            r_col_en  <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && start) begin
                r_nsz     <= CNT_W'(size_decode(N));
                r_iss_cnt <= '0;
                r_wr_cnt  <= '0;
                r_out_cnt <= '0;
            end else begin
                // The issue counter is reused for the column pass.
                if ((r_state == S_ROW_DRAIN) && (w_next == S_COL)) begin
                    r_iss_cnt <= '0;
                end else if (w_row_issue || w_col_issue) begin
                    r_iss_cnt <= r_iss_cnt + CNT_W'(1);
                end
                if (w_row_vld) begin
                    r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                end
                if (w_out_fire) begin
                    r_out_cnt <= r_out_cnt + CNT_W'(1);
                end
            end
            // Read-to-core stage: a pending issue waits out the hold.
            if (!w_hold) begin
                r_col_en <= w_col_issue;
            end
        end
    end

    assign bus.in_ready   = (r_state == S_ROW) & w_iss_below;
    assign bus.core_en    = w_row_issue | (r_col_en & ~w_hold);
    assign bus.core_hold  = w_hold;
    assign bus.direction  = (r_state == S_COL) | (r_state == S_COL_DRAIN);
    assign bus.tbuf_we    = w_row_vld;
    assign bus.tbuf_waddr = w_row_vld ? w_row_tag : '0;
    assign bus.tbuf_re    = w_col_issue;
    assign bus.tbuf_raddr = w_col_issue ? r_iss_cnt[CW-1:0] : '0;
    assign bus.out_valid  = w_col_vld;
    assign bus.out_idx    = w_col_vld ? w_col_tag : '0;

    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign current_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_dct2_2d_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dct2_2d_scheduler
// Description : Directed self-checking bench for dct2_2d_scheduler with
//               CORE_LAT=2, RD_LAT=1, CW=5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dct2_2d_scheduler;

    localparam int CW = 5;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] N     = 2'b00;
    logic       busy;
    logic       done;
    logic [2:0] current_state;

    int n_vec = 0;
    int n_err = 0;

    dct2_2d_scheduler_if #(.CW(CW)) bus ();

    dct2_2d_scheduler #(
        .CORE_LAT (2),
        .RD_LAT   (1),
        .CW       (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .N             (N),
        .bus           (bus.master),
        .busy          (busy),
        .done          (done),
        .current_state (current_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint all_outputs();
        return longint'({busy, done, current_state, bus.in_ready, bus.core_en,
                         bus.core_hold, bus.direction, bus.tbuf_we, bus.tbuf_waddr,
                         bus.tbuf_re, bus.tbuf_raddr, bus.out_valid, bus.out_idx});
    endfunction

    // Runs one block. Inputs change on the falling edge; outputs are sampled
    // 1 time unit later, i.e. the values the next rising edge will act on.
    task automatic run_block(input logic [1:0] n, input bit toggle_in,
                             input int stall_idx, input int stall_len,
                             input bit poke_start, input int reset_at_rd,
                             input string nm);
        int  nsz;
        int  row_en, wr, rd, outs, dones;
        int  first_en, first_wr, last_wr, done_cyc;
        int  wr_bad, rd_bad, out_bad, hold_bad, row_bad, done_early;
        int  stall_seen;
        bit  ready_low, stall_done;
        nsz = 4 << n;
        row_en = 0; wr = 0; rd = 0; outs = 0; dones = 0;
        first_en = -1; first_wr = -1; last_wr = -1; done_cyc = -1;
        wr_bad = 0; rd_bad = 0; out_bad = 0; hold_bad = 0; row_bad = 0; done_early = 0;
        stall_seen = 0; ready_low = 1'b0; stall_done = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start = (cyc == 0) || (poke_start && cyc >= 4 && cyc <= 6);
            if (cyc == 0) N = n;
            else if (poke_start && cyc == 4) N = ~n;
            bus.in_valid  = toggle_in ? ((cyc % 2) == 0) : 1'b1;
            bus.out_ready = !ready_low;
            #1;

            if (cyc == 1) check({nm, "_state_row"}, current_state, 1);

            if (current_state == 3'd1 && !bus.in_valid && bus.core_en) row_bad++;
            if (row_en >= nsz && bus.in_ready) row_bad++;
            if (bus.core_en && !bus.direction) begin
                if (first_en < 0) first_en = cyc;
                row_en++;
            end
            if (bus.tbuf_we) begin
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                if (bus.tbuf_waddr != wr[CW-1:0]) wr_bad++;
                wr++;
            end
            if (bus.tbuf_re) begin
                if (bus.tbuf_raddr != rd[CW-1:0]) rd_bad++;
                rd++;
            end

            if (ready_low && bus.out_valid) begin
                stall_seen++;
                if (bus.out_idx != stall_idx[CW-1:0] || !bus.core_hold ||
                    bus.core_en || bus.tbuf_re) hold_bad++;
                if (stall_seen == stall_len) ready_low = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (bus.out_idx != outs[CW-1:0]) out_bad++;
                outs++;
                if (stall_len > 0 && !stall_done && outs == stall_idx) begin
                    ready_low  = 1'b1;
                    stall_done = 1'b1;
                end
            end

            if (reset_at_rd > 0 && current_state == 3'd3 && rd >= reset_at_rd) begin
                rst_n = 1'b0;
                #1;
                check({nm, "_rst_outputs_zero"}, all_outputs(), 0);
                @(negedge clk);
                check({nm, "_rst_no_done"}, done, 0);
                @(negedge clk);
                check({nm, "_rst_state_idle"}, current_state, 0);
                rst_n = 1'b1;
                start = 1'b0;
                return;
            end

            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
                if (outs != nsz) done_early++;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check({nm, "_idle_after_done"}, {busy, done, current_state}, 0);
            end
            if (done_cyc >= 0 && cyc == done_cyc + 2) break;
        end

        start = 1'b0;
        N     = n;
        check({nm, "_completed"}, done_cyc >= 0, 1);
        check({nm, "_row_issues"}, row_en, nsz);
        check({nm, "_row_gating_errs"}, row_bad, 0);
        check({nm, "_tbuf_writes"}, wr, nsz);
        check({nm, "_waddr_order_errs"}, wr_bad, 0);
        check({nm, "_first_write_lat"}, first_wr - first_en, 2);
        if (!toggle_in) check({nm, "_last_write_lat"}, last_wr - first_en, nsz + 1);
        check({nm, "_tbuf_reads"}, rd, nsz);
        check({nm, "_raddr_order_errs"}, rd_bad, 0);
        check({nm, "_outputs"}, outs, nsz);
        check({nm, "_out_idx_order_errs"}, out_bad, 0);
        check({nm, "_done_pulses"}, dones, 1);
        check({nm, "_done_early"}, done_early, 0);
        if (stall_len > 0) begin
            check({nm, "_stall_cycles"}, stall_seen, stall_len);
            check({nm, "_hold_errs"}, hold_bad, 0);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_outputs_zero", all_outputs(), 0);
        rst_n = 1'b1;

        run_block(2'b00, 1'b0, 0, 0, 1'b0, 0, "n4_basic");
        run_block(2'b11, 1'b0, 0, 0, 1'b0, 0, "n32_full");
        run_block(2'b01, 1'b1, 0, 0, 1'b1, 0, "n8_toggle_restart");
        run_block(2'b01, 1'b0, 3, 5, 1'b0, 0, "n8_backpressure");
        run_block(2'b10, 1'b0, 0, 0, 1'b0, 5, "n16_reset_mid_col");
        run_block(2'b00, 1'b0, 0, 0, 1'b0, 0, "n4_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
